// File: rtl/fft_addr_generator_pkg.sv
// Shared FFT definitions: controller state encoding and butterfly-count helpers.
package fft_addr_generator_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StNext,
        StFin
    } fft_state_e;

    localparam int unsigned FFT_N_DEFAULT = 10;
    // Butterflies per stage for the default transform length.
    localparam int unsigned HALF_N = 1 << (FFT_N_DEFAULT - 1);

    // Butterflies per stage for an arbitrary log2 transform length.
    function automatic int unsigned half_n(input int unsigned fft_n);
        return 1 << (fft_n - 1);
    endfunction

endpackage

// File: rtl/fft_addr_generator_if.sv
// Control/address bundle between the FFT address generator and its butterfly datapath.
interface fft_addr_generator_if #(
    parameter int unsigned FFT_N             = 10,
    parameter int unsigned FFT_MAX_BIT_WIDTH = 5
);
    localparam int unsigned STAGE_W = $clog2(FFT_N);

    logic                         start;
    logic                         ifft_in;
    logic                         oact;
    logic [FFT_MAX_BIT_WIDTH-1:0] max_bit_width_current_FFT_stage;

    logic                         iact;
    logic [1:0]                   ictrl;
    logic [FFT_N-2:0]             MemAddr;
    logic [FFT_N-2:0]             twiddleFactorAddr;
    logic                         evenOdd;
    logic                         ifft;
    logic                         clr_bfp;
    logic [FFT_MAX_BIT_WIDTH-1:0] ibfp;
    logic                         busy;
    logic                         done;
    logic [STAGE_W-1:0]           stage;

    // Requester / butterfly side.
    modport master (
        output start, ifft_in, oact, max_bit_width_current_FFT_stage,
        input  iact, ictrl, MemAddr, twiddleFactorAddr, evenOdd, ifft, clr_bfp, ibfp,
               busy, done, stage
    );

    // Address generator side.
    modport slave (
        input  start, ifft_in, oact, max_bit_width_current_FFT_stage,
        output iact, ictrl, MemAddr, twiddleFactorAddr, evenOdd, ifft, clr_bfp, ibfp,
               busy, done, stage
    );

endinterface

// File: rtl/fft_addr_generator.sv
// In-place radix-2 FFT sequencer: issues one butterfly per cycle per stage, waits for all
// write-backs, then latches the stage's block-floating-point exponent before the next stage.
module fft_addr_generator
    import fft_addr_generator_pkg::*;
#(
    parameter int unsigned FFT_N             = 10,
    parameter int unsigned FFT_MAX_BIT_WIDTH = 5
) (
    input logic                clk,
    input logic                reset,
    fft_addr_generator_if.slave bus
);

    localparam int unsigned AW    = FFT_N - 1;
    localparam int unsigned CW    = FFT_N;
    localparam int unsigned SW    = $clog2(FFT_N);
    localparam int unsigned HalfN = half_n(FFT_N);

    localparam logic [AW-1:0] KLast     = AW'(HalfN - 1);
    localparam logic [CW-1:0] CntFull   = CW'(HalfN);
    localparam logic [SW-1:0] StageLast = SW'(FFT_N - 1);

    fft_state_e                   state_q;
    logic [AW-1:0]                k_q;
    logic [CW-1:0]                cnt_q;
    logic [SW-1:0]                stage_q;
    logic                         iact_q;
    logic [1:0]                   ictrl_q;
    logic [AW-1:0]                mem_addr_q;
    logic [AW-1:0]                tw_addr_q;
    logic                         even_odd_q;
    logic                         ifft_q;
    logic                         clr_bfp_q;
    logic [FFT_MAX_BIT_WIDTH-1:0] ibfp_q;
    logic                         busy_q;
    logic                         done_q;

    logic [CW-1:0]                mask_full;
    logic [AW-1:0]                tw_mask;
    logic [CW-1:0]                cnt_inc;

    // Twiddle mask clears the low (FFT_N-1-stage) bits; saturating write-back counter.
    always_comb begin
        mask_full = {CW{1'b1}} << (AW - 32'(stage_q));
        tw_mask   = mask_full[AW-1:0];
        cnt_inc   = cnt_q;
        if (bus.oact && (cnt_q != CntFull)) begin
            cnt_inc = cnt_q + 1'b1;
        end
    end

    // Sequencer FSM; every output is a register so issue fields move on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            cnt_q      <= '0;
            stage_q    <= '0;
            iact_q     <= 1'b0;
            ictrl_q    <= 2'b00;
            mem_addr_q <= '0;
            tw_addr_q  <= '0;
            even_odd_q <= 1'b0;
            ifft_q     <= 1'b0;
            clr_bfp_q  <= 1'b0;
            ibfp_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Issue fields and strobes are zero unless this cycle drives them.
            iact_q     <= 1'b0;
            ictrl_q    <= 2'b00;
            mem_addr_q <= '0;
            tw_addr_q  <= '0;
            even_odd_q <= 1'b0;
            clr_bfp_q  <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        ifft_q    <= bus.ifft_in;
                        stage_q   <= '0;
                        k_q       <= '0;
                        cnt_q     <= '0;
                        ibfp_q    <= '0;
                        clr_bfp_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    iact_q     <= 1'b1;
                    mem_addr_q <= k_q;
                    tw_addr_q  <= k_q & tw_mask;
                    even_odd_q <= stage_q[0];
                    if (k_q == '0) begin
                        ictrl_q <= 2'b01;
                    end else if (k_q == KLast) begin
                        ictrl_q <= 2'b10;
                    end
                    cnt_q <= cnt_inc;
                    k_q   <= k_q + 1'b1;
                    if (k_q == KLast) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == CntFull) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    ibfp_q <= bus.max_bit_width_current_FFT_stage;
                    if (stage_q == StageLast) begin
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        stage_q   <= stage_q + 1'b1;
                        k_q       <= '0;
                        cnt_q     <= '0;
                        clr_bfp_q <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.iact              = iact_q;
    assign bus.ictrl             = ictrl_q;
    assign bus.MemAddr           = mem_addr_q;
    assign bus.twiddleFactorAddr = tw_addr_q;
    assign bus.evenOdd           = even_odd_q;
    assign bus.ifft              = ifft_q;
    assign bus.clr_bfp           = clr_bfp_q;
    assign bus.ibfp              = ibfp_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.stage             = stage_q;

endmodule

// File: tb/tb_fft_addr_generator.sv
// Scoreboard bench for the FFT address generator at FFT_N=4 (8 butterflies per stage).
module tb_fft_addr_generator;

    localparam int unsigned N = 4;
    localparam int unsigned W = 5;

    typedef struct {
        int mem;
        int tw;
        int ictrl;
        int eo;
        int ibfp;
        int ifft;
    } rec_t;

    typedef struct {
        int ifft;
        int ibfp;
    } done_rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hold = 1'b0;
    logic [3:0] pipe = '0;
    int pend = 0;
    int clr_cnt = 0;
    int clr_base = 0;
    int n_checks = 0;
    int n_fail = 0;

    rec_t      exp_q[$];
    done_rec_t done_q[$];

    // Hand-derived twiddle indices per stage, and the stage max widths the model reports.
    int TW_TAB[4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                         '{0, 0, 0, 0, 4, 4, 4, 4},
                         '{0, 0, 2, 2, 4, 4, 6, 6},
                         '{0, 1, 2, 3, 4, 5, 6, 7}};
    int MBW[4] = '{7, 13, 21, 3};

    always #5 clk = ~clk;

    fft_addr_generator_if #(.FFT_N(N), .FFT_MAX_BIT_WIDTH(W)) bus ();

    fft_addr_generator #(.FFT_N(N), .FFT_MAX_BIT_WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Butterfly model: write-back a few cycles after issue, optionally withheld; max width per stage.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pipe = '0;
            pend = 0;
            bus.oact = 1'b0;
        end else begin
            pipe = {pipe[2:0], bus.iact};
            pend = pend + int'(pipe[3]);
            if (!hold && pend > 0) begin
                bus.oact = 1'b1;
                pend--;
            end else begin
                bus.oact = 1'b0;
            end
        end
        bus.max_bit_width_current_FFT_stage = W'(MBW[bus.stage]);
    end

    // Monitor: pops the expected issue / completion record whenever the DUT presents one.
    always @(negedge clk) begin
        rec_t r;
        done_rec_t d;
        if (!reset) begin
            if (bus.clr_bfp) clr_cnt++;
            if (bus.iact) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got iact=1 MemAddr=%0d, required no issue",
                             bus.MemAddr);
                end else begin
                    r = exp_q.pop_front();
                    check("mem_addr", int'(bus.MemAddr), r.mem);
                    check("twiddle_addr", int'(bus.twiddleFactorAddr), r.tw);
                    check("ictrl", int'(bus.ictrl), r.ictrl);
                    check("even_odd", int'(bus.evenOdd), r.eo);
                    check("ibfp_in_stage", int'(bus.ibfp), r.ibfp);
                    check("ifft_in_stage", int'(bus.ifft), r.ifft);
                    check("busy_in_issue", int'(bus.busy), 1);
                end
            end else begin
                check("idle_issue_fields",
                      int'({bus.ictrl, bus.MemAddr, bus.twiddleFactorAddr, bus.evenOdd}), 0);
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required no completion");
                end else begin
                    d = done_q.pop_front();
                    check("ifft_at_done", int'(bus.ifft), d.ifft);
                    check("ibfp_at_done", int'(bus.ibfp), d.ibfp);
                end
            end
        end
    end

    task automatic push_transform(input int ifft_v);
        rec_t r;
        done_rec_t d;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                r.mem   = k;
                r.tw    = TW_TAB[s][k];
                r.ictrl = (k == 0) ? 1 : ((k == 7) ? 2 : 0);
                r.eo    = s % 2;
                r.ibfp  = (s == 0) ? 0 : MBW[s-1];
                r.ifft  = ifft_v;
                exp_q.push_back(r);
            end
        end
        d.ifft = ifft_v;
        d.ibfp = MBW[3];
        done_q.push_back(d);
    endtask

    // Issue a start pulse (called at posedge+1) and check acceptance on the following cycle.
    task automatic run_start(input int ifft_v);
        push_transform(ifft_v);
        clr_base = clr_cnt;
        bus.start = 1'b1;
        bus.ifft_in = 1'(ifft_v);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ifft_in = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("clr_bfp_after_start", int'(bus.clr_bfp), 1);
    endtask

    task automatic wait_stage(input int s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (int'(bus.stage) == s) break;
        end
        check("stage_reached", int'(bus.stage), s);
    endtask

    task automatic wait_done(input int ifft_v);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) break;
        end
        check("done_seen", int'(bus.done), 1);
        check("busy_at_done", int'(bus.busy), 1);
        check("ifft_held", int'(bus.ifft), ifft_v);
        check("clr_bfp_pulses", clr_cnt - clr_base, 4);
        @(posedge clk);
        #1;
        check("busy_after_done", int'(bus.busy), 0);
        check("done_one_cycle", int'(bus.done), 0);
        check("ibfp_hold", int'(bus.ibfp), MBW[3]);
        check("issues_left", exp_q.size(), 0);
        check("dones_left", done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_iact"}, int'(bus.iact), 0);
        check({tag, "_ictrl"}, int'(bus.ictrl), 0);
        check({tag, "_mem_addr"}, int'(bus.MemAddr), 0);
        check({tag, "_twiddle"}, int'(bus.twiddleFactorAddr), 0);
        check({tag, "_even_odd"}, int'(bus.evenOdd), 0);
        check({tag, "_ifft"}, int'(bus.ifft), 0);
        check({tag, "_clr_bfp"}, int'(bus.clr_bfp), 0);
        check({tag, "_ibfp"}, int'(bus.ibfp), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_stage"}, int'(bus.stage), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.ifft_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Inverse transform; a start during stage 1 must be ignored.
        run_start(1);
        wait_stage(1, 100);
        bus.start = 1'b1;
        bus.ifft_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_ignored_start", int'(bus.busy), 1);
        check("no_clr_on_ignored_start", int'(bus.clr_bfp), 0);
        wait_done(1);

        // Withheld write-backs keep stage 0 in drain; late pulses release it.
        hold = 1'b1;
        run_start(0);
        repeat (29) @(posedge clk);
        #1;
        check("hold_iact", int'(bus.iact), 0);
        check("hold_busy", int'(bus.busy), 1);
        check("hold_stage", int'(bus.stage), 0);
        check("hold_no_next", clr_cnt - clr_base, 1);
        hold = 1'b0;
        wait_stage(1, 30);
        wait_done(0);

        // Reset in the middle of stage 2 at k=3.
        run_start(1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.iact && bus.stage == 2'd2 && bus.MemAddr == 3'd3) break;
        end
        check("reset_point_found",
              int'(bus.iact && bus.stage == 2'd2 && bus.MemAddr == 3'd3), 1);
        check("ibfp_before_reset", int'(bus.ibfp), MBW[1]);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        done_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clean transform after the abort.
        run_start(0);
        wait_done(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_addr_generator.md
FFT_ADDR_GENERATOR -- requirements
Module: fft_addr_generator

Interface
REQ-001 SHALL have parameter FFT_N, default 10, meaning log2 of transform length; minimum value is 2.
REQ-002 SHALL have parameter FFT_MAX_BIT_WIDTH, default 5, meaning the width of the block-floating-point exponent fields.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, requesting a new transform.
REQ-006 SHALL have port ifft_in, input, 1 bit, selecting inverse transform; sampled only when a start is accepted.
REQ-007 SHALL have port oact, input, 1 bit, the butterfly unit's per-butterfly write-back strobe.
REQ-008 SHALL have port max_bit_width_current_FFT_stage, input, FFT_MAX_BIT_WIDTH bits, the stage maximum width reported by the butterfly unit.
REQ-009 SHALL have port iact, output, 1 bit, the butterfly issue strobe.
REQ-010 SHALL have port ictrl, output, 2 bits: bit0 marks the first butterfly of a stage, bit1 marks the last.
REQ-011 SHALL have port MemAddr, output, FFT_N-1 bits, the RAM pair read address.
REQ-012 SHALL have port twiddleFactorAddr, output, FFT_N-1 bits, the twiddle index.
REQ-013 SHALL have port evenOdd, output, 1 bit, the ping-pong direction.
REQ-014 SHALL have port ifft, output, 1 bit, the latched transform direction.
REQ-015 SHALL have port clr_bfp, output, 1 bit, clearing the butterfly unit's BFP tracker.
REQ-016 SHALL have port ibfp, output, FFT_MAX_BIT_WIDTH bits, the exponent applied to the current stage.
REQ-017 SHALL have port busy, output, 1 bit, high while a transform is in progress.
REQ-018 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-019 SHALL have port stage, output, clog2(FFT_N) bits, the current stage index.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> NEXT -> (ISSUE | FIN) -> IDLE.
REQ-021 SHALL, in IDLE, on start=1: latch ifft_in, set stage=0, k=0, ibfp=0, and pulse clr_bfp, then enter ISSUE on the next cycle.
REQ-022 SHALL, in ISSUE, assert iact every cycle with MemAddr=k, then increment k; after k=2^(FFT_N-1)-1 is issued, enter DRAIN (2^(FFT_N-1) butterflies, no gaps).
REQ-023 SHALL drive twiddleFactorAddr = k with its low (FFT_N-1-stage) bits forced to zero.
REQ-024 SHALL drive evenOdd = stage[0].
REQ-025 SHALL drive ictrl=2'b01 on k=0, 2'b10 on the last k, and 2'b00 otherwise; all iact-qualified outputs are 0 when iact=0.
REQ-026 SHALL count oact pulses per stage in ISSUE and DRAIN, and leave DRAIN once the count reaches 2^(FFT_N-1); latency to oact is arbitrary.
REQ-027 SHALL, in NEXT (one cycle), register ibfp <= max_bit_width_current_FFT_stage and pulse clr_bfp.
REQ-028 SHALL, at the end of NEXT, go to FIN if stage=FFT_N-1; otherwise increment stage, clear k and the oact count, and go to ISSUE.
REQ-029 SHALL, in FIN, pulse done for one cycle and return to IDLE; ibfp and ifft hold their values until the next start.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL ignore start while busy, and ignore oact in IDLE and NEXT.
REQ-032 SHALL saturate the oact count at 2^(FFT_N-1).
REQ-033 SHALL register all outputs; iact, MemAddr, twiddleFactorAddr, ictrl and evenOdd change together on the same edge.

Reset
REQ-034 SHALL, when reset=1 (including mid-transform), enter IDLE and clear iact, ictrl, MemAddr, twiddleFactorAddr, evenOdd, ifft, clr_bfp, ibfp, busy, done, stage, k and the oact count to 0 at the next edge.
REQ-035 SHALL give reset priority over start and oact in the same cycle.

Structure
REQ-036 SHALL place the FSM state enum and localparam HALF_N = 2^(FFT_N-1) in the shared FFT package.
REQ-037 SHALL contain no sub-module; the twiddle masking is inline logic.

Verification (FFT_N=4, 8 butterflies/stage; butterfly model returns oact 4 cycles after iact)
REQ-038 SHALL verify: start pulse -> busy the next cycle; stage 0 issues MemAddr 0..7 with twiddleFactorAddr all 0, ictrl 01 on the first and 10 on the last; done after 4 stages, each separated by drain plus NEXT.
REQ-039 SHALL verify the stage-2 twiddle sequence 0,0,2,2,4,4,6,6 and the stage-3 sequence 0..7; evenOdd toggles 0,1,0,1 across stages.
REQ-040 SHALL verify that max_bit_width_current_FFT_stage=13 at the end of stage 1 gives ibfp=13 throughout stage 2, with clr_bfp pulsed exactly 4 times (once at start, once per NEXT except the last).
REQ-041 SHALL verify that start asserted during stage 1 is ignored, and that ifft_in=1 at the accepted start holds ifft=1 until done.
REQ-042 SHALL verify that reset asserted at stage 2, k=3 gives all outputs 0 and busy=0 the next cycle, and that a following start runs a clean transform.
REQ-043 SHALL verify that withholding oact for 20 cycles keeps the FSM in DRAIN with iact=0, and that 8 late pulses release it to NEXT.
